// File: rtl/mips32i_single_cycle.sv
// Single-cycle MIPS-I integer core: decodes and executes one instruction per
// clock from inst_in, holds the 32x32 register file and ALU, and drives a
// word-addressed data-memory port. Sub-word stores are read-modify-write on
// the word presented on data_in, using big-endian byte lanes.
module mips32i_single_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [29:0] address_out,
  output logic        mem_wt_en
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] eff_addr;
  logic [1:0]  byte_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic        wr_en_next;
  logic [4:0]  wr_addr_next;
  logic [31:0] wr_data_next;
  logic        store_next;

  logic [31:0] regs_reg [32];

  assign opcode = inst_in[31:26];
  assign rs_idx = inst_in[25:21];
  assign rt_idx = inst_in[20:16];
  assign rd_idx = inst_in[15:11];
  assign shamt  = inst_in[10:6];
  assign funct  = inst_in[5:0];
  assign imm    = inst_in[15:0];

  // $0 is forced to zero on read so it never depends on its storage
  assign rs_val = (rs_idx == 5'd0) ? 32'd0 : regs_reg[rs_idx];
  assign rt_val = (rt_idx == 5'd0) ? 32'd0 : regs_reg[rt_idx];

  assign imm_sext    = {{16{imm[15]}}, imm};
  assign imm_zext    = {16'd0, imm};
  assign eff_addr    = rs_val + imm_sext;
  assign address_out = eff_addr[31:2];
  assign byte_off    = eff_addr[1:0];
  assign ld_half     = byte_off[1] ? data_in[15:0] : data_in[31:16];

  // Big-endian byte lane select for byte loads: offset 0 is the MSB lane
  always_comb begin
    case (byte_off)
      2'd0:    ld_byte = data_in[31:24];
      2'd1:    ld_byte = data_in[23:16];
      2'd2:    ld_byte = data_in[15:8];
      default: ld_byte = data_in[7:0];
    endcase
  end

  // Instruction decode and execute: register write-back and store data
  always_comb begin
    wr_en_next   = 1'b0;
    wr_addr_next = rt_idx;
    wr_data_next = 32'd0;
    store_next   = 1'b0;
    data_out     = rt_val;
    case (opcode)
      OP_RTYPE: begin
        wr_en_next   = 1'b1;
        wr_addr_next = rd_idx;
        case (funct)
          6'h20, 6'h21: wr_data_next = rs_val + rt_val;
          6'h22, 6'h23: wr_data_next = rs_val - rt_val;
          6'h24:        wr_data_next = rs_val & rt_val;
          6'h25:        wr_data_next = rs_val | rt_val;
          6'h26:        wr_data_next = rs_val ^ rt_val;
          6'h27:        wr_data_next = ~(rs_val | rt_val);
          6'h2A:        wr_data_next = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B:        wr_data_next = {31'd0, rs_val < rt_val};
          6'h00:        wr_data_next = rt_val << shamt;
          6'h02:        wr_data_next = rt_val >> shamt;
          6'h03:        wr_data_next = $signed(rt_val) >>> shamt;
          6'h04:        wr_data_next = rt_val << rs_val[4:0];
          6'h06:        wr_data_next = rt_val >> rs_val[4:0];
          6'h07:        wr_data_next = $signed(rt_val) >>> rs_val[4:0];
          default:      wr_en_next   = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        wr_en_next   = 1'b1;
        wr_data_next = rs_val + imm_sext;
      end
      OP_SLTI: begin
        wr_en_next   = 1'b1;
        wr_data_next = {31'd0, $signed(rs_val) < $signed(imm_sext)};
      end
      OP_SLTIU: begin
        wr_en_next   = 1'b1;
        wr_data_next = {31'd0, rs_val < imm_sext};
      end
      OP_ANDI: begin
        wr_en_next   = 1'b1;
        wr_data_next = rs_val & imm_zext;
      end
      OP_ORI: begin
        wr_en_next   = 1'b1;
        wr_data_next = rs_val | imm_zext;
      end
      OP_XORI: begin
        wr_en_next   = 1'b1;
        wr_data_next = rs_val ^ imm_zext;
      end
      OP_LUI: begin
        wr_en_next   = 1'b1;
        wr_data_next = {imm, 16'd0};
      end
      OP_LB: begin
        wr_en_next   = 1'b1;
        wr_data_next = {{24{ld_byte[7]}}, ld_byte};
      end
      OP_LBU: begin
        wr_en_next   = 1'b1;
        wr_data_next = {24'd0, ld_byte};
      end
      OP_LH: begin
        wr_en_next   = 1'b1;
        wr_data_next = {{16{ld_half[15]}}, ld_half};
      end
      OP_LHU: begin
        wr_en_next   = 1'b1;
        wr_data_next = {16'd0, ld_half};
      end
      OP_LW: begin
        wr_en_next   = 1'b1;
        wr_data_next = data_in;
      end
      OP_SW: begin
        store_next = 1'b1;
      end
      OP_SH: begin
        store_next = 1'b1;
        data_out   = byte_off[1] ? {data_in[31:16], rt_val[15:0]}
                                 : {rt_val[15:0], data_in[15:0]};
      end
      OP_SB: begin
        store_next = 1'b1;
        case (byte_off)
          2'd0:    data_out = {rt_val[7:0], data_in[23:0]};
          2'd1:    data_out = {data_in[31:24], rt_val[7:0], data_in[15:0]};
          2'd2:    data_out = {data_in[31:16], rt_val[7:0], data_in[7:0]};
          default: data_out = {data_in[31:8], rt_val[7:0]};
        endcase
      end
      default: ;
    endcase
    // Writes to memory are suppressed for as long as reset is held
    mem_wt_en = store_next & rst;
  end

  // Register file write port: clear all on reset, otherwise write-back (never $0)
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= 32'd0;
      end
    end else if (wr_en_next && (wr_addr_next != 5'd0)) begin
      regs_reg[wr_addr_next] <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_mips32i_single_cycle.sv
// Directed-vector bench for mips32i_single_cycle with a small word memory.
// Register contents are observed by presenting "sw r,0x40($0)" and reading
// data_out combinationally, without clocking that store.
module tb_mips32i_single_cycle;

  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] ZERO = 5'd0;
  localparam logic [4:0] T0 = 5'd8;
  localparam logic [4:0] T1 = 5'd9;
  localparam logic [4:0] T2 = 5'd10;
  localparam logic [4:0] T3 = 5'd11;
  localparam logic [4:0] T4 = 5'd12;
  localparam logic [4:0] S0 = 5'd16;
  localparam logic [4:0] S1 = 5'd17;
  localparam logic [4:0] S2 = 5'd18;
  localparam logic [4:0] S3 = 5'd19;

  logic        tb_clk;
  logic        rst;
  logic [31:0] inst_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [29:0] address_out;
  logic        mem_wt_en;

  logic [31:0] mem [64];
  int          checks;
  int          errors;

  mips32i_single_cycle dut (
    .clk         (tb_clk),
    .rst         (rst),
    .inst_in     (inst_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .address_out (address_out),
    .mem_wt_en   (mem_wt_en)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Data memory: asynchronous read, write on the rising edge
  assign data_in = mem[address_out[5:0]];
  always @(posedge tb_clk) begin
    if (mem_wt_en) mem[address_out[5:0]] <= data_out;
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Present an instruction and let it retire at the next rising edge
  task automatic exec(input logic [31:0] ins);
    inst_in = ins;
    @(posedge tb_clk);
    #1;
  endtask

  // Show a register on data_out via an unclocked sw
  task automatic peek_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    inst_in = itype(OP_SW, ZERO, r, 16'h0040);
    #1;
    check_value(tag, data_out, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst     = 1'b0;
    inst_in = 32'd0;
    repeat (2) @(posedge tb_clk);
    #1;

    // Reset state
    inst_in = itype(OP_SW, ZERO, S3, 16'h0000);
    #1;
    check_value("rst_wt_en", {31'd0, mem_wt_en}, 32'd0);
    peek_reg("rst_s0", S0, 32'd0);
    rst = 1'b1;

    // ALU chain
    exec(itype(OP_ADDI, ZERO, S0, 16'd22));
    exec(itype(OP_ADDI, ZERO, T1, 16'd15));
    exec(rtype(S0, T1, S1, 5'd0, 6'h20));
    exec(rtype(S0, T1, T2, 5'd0, 6'h22));
    peek_reg("addi_s0", S0, 32'd22);
    peek_reg("add_s1", S1, 32'd37);
    peek_reg("sub_t2", T2, 32'd7);

    // Logic
    exec(itype(OP_ANDI, T1, T0, 16'h003C));     peek_reg("andi", T0, 32'h0000000C);
    exec(rtype(S0, T1, T0, 5'd0, 6'h24));       peek_reg("and",  T0, 32'h00000006);
    exec(rtype(S0, T1, T0, 5'd0, 6'h25));       peek_reg("or",   T0, 32'h0000001F);
    exec(itype(OP_ORI, T1, T0, 16'h003C));      peek_reg("ori",  T0, 32'h0000003F);
    exec(rtype(S0, T1, T0, 5'd0, 6'h26));       peek_reg("xor",  T0, 32'h00000019);
    exec(itype(OP_XORI, T1, T0, 16'h003C));     peek_reg("xori", T0, 32'h00000033);
    exec(rtype(S0, T1, T0, 5'd0, 6'h27));       peek_reg("nor",  T0, 32'hFFFFFFE0);

    // Compare
    exec(rtype(T1, S0, S2, 5'd0, 6'h2A));       peek_reg("slt",  S2, 32'd1);
    exec(itype(OP_SLTI, T1, S2, 16'd10));       peek_reg("slti", S2, 32'd0);
    exec(itype(OP_ADDI, ZERO, T3, 16'hFFFF));   peek_reg("t3_m1", T3, 32'hFFFFFFFF);
    exec(itype(OP_ADDI, ZERO, T4, 16'd5));
    exec(rtype(T3, T4, S2, 5'd0, 6'h2B));       peek_reg("sltu_m1", S2, 32'd0);
    exec(rtype(T3, T4, S2, 5'd0, 6'h2A));       peek_reg("slt_m1",  S2, 32'd1);
    exec(itype(OP_SLTIU, T3, S2, 16'd5));       peek_reg("sltiu_m1", S2, 32'd0);
    exec(itype(OP_SLTI, T3, S2, 16'd5));        peek_reg("slti_m1", S2, 32'd1);

    // Shifts
    exec(itype(OP_LUI, ZERO, S2, 16'hF00F));    peek_reg("lui", S2, 32'hF00F0000);
    exec(rtype(ZERO, S2, S3, 5'd6, 6'h00));     peek_reg("sll", S3, 32'h03C00000);
    exec(rtype(ZERO, S2, S3, 5'd6, 6'h02));     peek_reg("srl", S3, 32'h03C03C00);
    exec(rtype(ZERO, S2, S3, 5'd6, 6'h03));     peek_reg("sra", S3, 32'hFFC03C00);
    exec(itype(OP_ADDI, ZERO, T0, 16'd6));
    exec(rtype(T0, S2, S3, 5'd0, 6'h04));       peek_reg("sllv", S3, 32'h03C00000);
    exec(rtype(T0, S2, S3, 5'd0, 6'h06));       peek_reg("srlv", S3, 32'h03C03C00);
    exec(rtype(T0, S2, S3, 5'd0, 6'h07));       peek_reg("srav", S3, 32'hFFC03C00);

    // Memory: word store then loads
    inst_in = itype(OP_SW, ZERO, S3, 16'h0000);
    #1;
    check_value("sw_wt_en", {31'd0, mem_wt_en}, 32'd1);
    check_value("sw_addr", {2'd0, address_out}, 32'd0);
    check_value("sw_data", data_out, 32'hFFC03C00);
    @(posedge tb_clk);
    #1;
    exec(itype(OP_LW,  ZERO, T0, 16'd0));       peek_reg("lw",  T0, 32'hFFC03C00);
    exec(itype(OP_LB,  ZERO, T0, 16'd1));       peek_reg("lb1", T0, 32'hFFFFFFC0);
    exec(itype(OP_LBU, ZERO, T0, 16'd1));       peek_reg("lbu1", T0, 32'h000000C0);
    exec(itype(OP_LHU, ZERO, T0, 16'd2));       peek_reg("lhu2", T0, 32'h00003C00);
    exec(itype(OP_LH,  ZERO, T0, 16'd0));       peek_reg("lh0", T0, 32'hFFFFFFC0);

    // Byte store read-modify-write
    exec(itype(OP_ADDI, ZERO, T4, 16'h00AA));
    inst_in = itype(OP_SB, ZERO, T4, 16'd3);
    #1;
    check_value("sb_wt_en", {31'd0, mem_wt_en}, 32'd1);
    check_value("sb_data", data_out, 32'hFFC03CAA);
    @(posedge tb_clk);
    #1;
    exec(itype(OP_LW, ZERO, T0, 16'd0));        peek_reg("lw_after_sb", T0, 32'hFFC03CAA);

    // Half store at offset 0 (not clocked) and non-zero base address
    inst_in = itype(OP_SH, ZERO, T4, 16'd0);
    #1;
    check_value("sh_data", data_out, 32'h00AA3CAA);
    inst_in = itype(OP_SW, T4, S3, 16'd4);
    #1;
    check_value("sw_base_addr", {2'd0, address_out}, 32'h0000002B);

    // $0 stays zero; overflow wraps
    exec(itype(OP_ADDI, ZERO, ZERO, 16'd5));    peek_reg("zero_reg", ZERO, 32'd0);
    exec(itype(OP_LUI, ZERO, T0, 16'h7FFF));
    exec(itype(OP_ORI, T0, T0, 16'hFFFF));
    exec(itype(OP_ADDI, ZERO, T4, 16'd1));
    exec(rtype(T0, T4, S1, 5'd0, 6'h20));       peek_reg("add_ovf", S1, 32'h80000000);

    // Unknown opcode and unknown funct act as NOPs
    inst_in = itype(6'h04, ZERO, S1, 16'h1234);
    #1;
    check_value("nop_wt_en", {31'd0, mem_wt_en}, 32'd0);
    @(posedge tb_clk);
    #1;
    peek_reg("nop_op_s1", S1, 32'h80000000);
    exec(rtype(S0, T1, S1, 5'd0, 6'h18));       peek_reg("nop_fn_s1", S1, 32'h80000000);

    // Reset mid-program: store suppressed, in-flight write aborted, regs cleared
    rst = 1'b0;
    inst_in = itype(OP_SW, ZERO, S3, 16'h0000);
    #1;
    check_value("midrst_wt_en", {31'd0, mem_wt_en}, 32'd0);
    exec(itype(OP_ADDI, ZERO, S0, 16'd99));
    rst = 1'b1;
    peek_reg("midrst_s0", S0, 32'd0);
    peek_reg("midrst_s3", S3, 32'd0);
    exec(itype(OP_LW, ZERO, T0, 16'd0));        peek_reg("midrst_mem", T0, 32'hFFC03CAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
